uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter TXBUSY_TIMEOUT, default 4, cycles allowed for txbusy to rise after a load pulse.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr  input  1  push request from bus side; one byte per high cycle.
REQ-006 SHALL have port din  input  8  byte to push, sampled when wr high.
REQ-007 SHALL have port clr_ovf  input  1  clears sticky overflow flag.
REQ-008 SHALL have port txbusy  input  1  UART transmitter busy; no load while high.
REQ-009 SHALL have port load  output  1  one-cycle load strobe to the UART transmitter.
REQ-010 SHALL have port d  output  8  byte to the UART, stable from the load cycle until txbusy falls.
REQ-011 SHALL have port full  output  1  level == DEPTH.
REQ-012 SHALL have port empty  output  1  level == 0.
REQ-013 SHALL have port level  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky flag: a push was dropped.

Function
REQ-015 SHALL store bytes in a circular buffer with rd/wr pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-016 SHALL accept a push when wr=1 and full=0; the write lands at wr_ptr and level updates on the same edge.
REQ-017 SHALL drop a push when wr=1 and full=1, leave contents and pointers unchanged, and set overflow on that edge.
REQ-018 SHALL clear overflow when clr_ovf=1; if a drop and clr_ovf occur in the same cycle, overflow SHALL end set.
REQ-019 SHALL treat a simultaneous push and pop as valid: level unchanged and both pointers advance, including when full (a pop frees the slot in the same edge).
REQ-020 SHALL implement a drain FSM with states IDLE, LOAD, WAIT_HI, WAIT_LO.
REQ-021 IDLE: when empty=0 and txbusy=0, SHALL register d <= mem[rd_ptr], pop (rd_ptr+1, level-1), and go to LOAD.
REQ-022 LOAD: SHALL assert load for exactly one cycle, then go to WAIT_HI.
REQ-023 WAIT_HI: SHALL go to WAIT_LO when txbusy=1, or after TXBUSY_TIMEOUT cycles without txbusy go to IDLE (byte treated as sent).
REQ-024 WAIT_LO: SHALL go to IDLE when txbusy=0.
REQ-025 Latency: a push into an empty FIFO with txbusy=0 SHALL produce load exactly 2 cycles after the wr cycle (pop in cycle 1, load in cycle 2).
REQ-026 The next load in a back-to-back stream SHALL occur no earlier than 2 cycles after txbusy falls.
REQ-027 d SHALL hold its value outside IDLE->LOAD transitions.
REQ-028 load SHALL never assert while txbusy=1 was sampled high in the preceding IDLE decision cycle.

Reset
REQ-029 While rst=0, pointers SHALL be 0, level 0, empty 1, full 0, overflow 0, load 0, d 8'h00, FSM in IDLE; memory contents are undefined.
REQ-030 Reset assertion mid-transfer SHALL abort immediately with no further load; a byte already loaded into the UART is not recalled.
REQ-031 Reset deassertion SHALL be synchronised externally; the block does not act in the first cycle after release.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2 bits) and the clog2 helper function.
REQ-033 The storage SHALL be one sub-module, fifo_ram (DEPTH x 8, synchronous write, combinational read), inferable as iCE40 LUT/BRAM.
REQ-034 Pointer, level, flag and drain FSM logic SHALL reside in uart_tx_fifo itself.

Verification
REQ-035 Reset, push 8'h41 with txbusy held 0 -> load=1 exactly 2 cycles after wr, with d=8'h41 and empty=1 after the pop.
REQ-036 Push 16 bytes 8'h00..8'h0F while txbusy=1 -> full=1, level=16; 17th push 8'hFF -> overflow=1, contents unchanged; release txbusy -> bytes emerge in order 8'h00..8'h0F.
REQ-037 With full=1, push and pop in the same cycle -> level stays 16, overflow stays 0, wrapped pointer order preserved.
REQ-038 Model txbusy rising 1 cycle after load and lasting 80 cycles -> exactly one load per byte, spaced at least 82 cycles apart.
REQ-039 txbusy never rises after load -> FSM returns to IDLE after 4 cycles and the next byte loads.
REQ-040 Assert rst in WAIT_LO with 3 bytes queued -> level=0, load=0 while in reset; no load for 1 cycle after release.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: drain FSM state encoding and width helper shared by the FIFO files
package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_ram.sv
// fifo_ram: DEPTH x 8 storage, synchronous write, combinational read
module fifo_ram
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // write port; contents are left undefined by reset
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO draining into a UART transmitter via a load/txbusy handshake
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TXBUSY_TIMEOUT = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr,
   input  logic [7:0]            din,
   input  logic                  clr_ovf,
   input  logic                  txbusy,
   output logic                  load,
   output logic [7:0]            d,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] level,
   output logic                  overflow
);

   localparam int AW = clog2(DEPTH);
   localparam int TW = clog2(TXBUSY_TIMEOUT + 1);

   state_t        state;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] cnt;
   logic [7:0]    rdata;
   logic          pop, push, drop;

   assign full  = level == (AW + 1)'(DEPTH);
   assign empty = level == '0;
   // a pop in the same edge frees a slot, so a push while full is still taken
   assign pop   = state == IDLE && !empty && !txbusy;
   assign push  = wr && (!full || pop);
   assign drop  = wr && full && !pop;

   fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // pointers, occupancy and sticky overflow; a drop wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         overflow <= drop || (overflow && !clr_ovf);
      end

   // drain FSM: pop into d, strobe load, then wait for the transmitter to finish or time out
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         load  <= 1'b0;
         d     <= 8'h00;
         cnt   <= '0;
      end else begin
         load <= 1'b0;
         case (state)
            IDLE:
               if (pop) begin
                  d     <= rdata;
                  load  <= 1'b1;
                  state <= LOAD;
               end
            LOAD: begin
               cnt   <= '0;
               state <= WAIT_HI;
            end
            WAIT_HI:
               if (txbusy) state <= WAIT_LO;
               else if (cnt == TW'(TXBUSY_TIMEOUT - 1)) state <= IDLE;
               else cnt <= cnt + 1'b1;
            WAIT_LO:
               if (!txbusy) state <= IDLE;
            default: state <= IDLE;
         endcase
      end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a queue model
module tb_uart_tx_fifo;

   logic       clk = 1'b0, rst = 1'b0, wr = 1'b0, clr_ovf = 1'b0;
   logic       man_busy = 1'b0, uart_mode = 1'b0, uart_busy = 1'b0;
   logic [7:0] din = 8'h00;
   logic       txbusy;
   logic       load, full, empty, overflow;
   logic [7:0] d;
   logic [4:0] level;
   int         n_cmp = 0, n_bad = 0;
   int         busy_len = 0;
   int         rem = 0;
   logic       pend = 1'b0, prev_busy = 1'b0;

   assign txbusy = uart_mode ? uart_busy : man_busy;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(16), .TXBUSY_TIMEOUT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .din      (din),
      .clr_ovf  (clr_ovf),
      .txbusy   (txbusy),
      .load     (load),
      .d        (d),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_load(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!load && n < max);
   endtask

   // UART stand-in: busy rises the cycle after load and stays high busy_len cycles
   always begin
      @(posedge clk);
      #1;
      if (!uart_mode) begin
         pend = 1'b0;
         rem = 0;
         uart_busy = 1'b0;
      end else begin
         if (pend) begin
            pend = 1'b0;
            if (busy_len > 0) begin
               uart_busy = 1'b1;
               rem = busy_len;
            end
         end else if (rem > 0) begin
            rem--;
            if (rem == 0) uart_busy = 1'b0;
         end
         if (load) pend = 1'b1;
      end
   end

   // a load must never follow a cycle in which txbusy was high
   always @(negedge clk) begin
      if (load) chk("load_after_busy", 32'(prev_busy), 0);
      prev_busy = txbusy;
   end

   initial begin
      int         n;
      int         lt[$];
      logic [7:0] q[$];
      logic       ovf_m, drp;
      logic [7:0] exp_b;

      // reset state
      repeat (2) tick();
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_load", load, 0);
      chk("rst_d", d, 8'h00);
      rst = 1'b1;
      repeat (2) tick();

      // single byte latency: load two cycles after wr
      wr = 1'b1; din = 8'h41;
      tick();
      wr = 1'b0;
      chk("lat_c1_load", load, 0);
      chk("lat_c1_level", level, 1);
      tick();
      chk("lat_load", load, 1);
      chk("lat_d", d, 8'h41);
      chk("lat_empty", empty, 1);
      repeat (8) tick();
      chk("lat_d_hold", d, 8'h41);
      chk("lat_load_once", load, 0);

      // txbusy never rises: WAIT_HI times out and the next byte loads
      wr = 1'b1; din = 8'hA1;
      tick();
      din = 8'hA2;
      tick();
      wr = 1'b0;
      chk("to_load1", load, 1);
      chk("to_d1", d, 8'hA1);
      wait_load(20, n);
      chk("to_gap", n, 6);
      chk("to_d2", d, 8'hA2);
      repeat (8) tick();

      // fill to full while busy, then a dropped push
      man_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr = 1'b1; din = 8'(i);
         tick();
      end
      chk("fill_full", full, 1);
      chk("fill_level", level, 16);
      chk("fill_ovf", overflow, 0);
      din = 8'hFF;
      tick();
      wr = 1'b0;
      chk("drop_ovf", overflow, 1);
      chk("drop_level", level, 16);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_ovf", overflow, 0);

      // push and pop together while full
      uart_mode = 1'b1; busy_len = 3;
      wr = 1'b1; din = 8'h10;
      tick();
      wr = 1'b0;
      chk("fp_level", level, 16);
      chk("fp_ovf", overflow, 0);
      chk("fp_load", load, 1);
      chk("fp_d0", d, 8'h00);
      for (int i = 1; i <= 16; i++) begin
         wait_load(40, n);
         chk("fp_seen", load, 1);
         chk("fp_order", d, 32'(i));
      end
      repeat (20) tick();
      chk("fp_empty", empty, 1);

      // long busy: one load per byte, spaced at least 82 cycles
      busy_len = 80;
      for (int i = 0; i < 3; i++) begin
         wr = 1'b1; din = 8'hB0 + 8'(i);
         tick();
         if (load) lt.push_back(-2 + i);
      end
      wr = 1'b0;
      for (int c = 0; c < 400; c++) begin
         tick();
         if (load) begin
            exp_b = 8'hB0 + 8'(lt.size());
            chk("bb_d", d, exp_b);
            lt.push_back(c);
         end
      end
      chk("bb_count", lt.size(), 3);
      for (int k = 1; k < lt.size(); k++)
         chk("bb_gap_ge82", 32'((lt[k] - lt[k-1]) >= 82), 1);

      // reset while waiting for txbusy to fall with three bytes queued
      uart_mode = 1'b0; man_busy = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         wr = 1'b1; din = 8'hC0 + 8'(i);
         tick();
      end
      wr = 1'b0;
      uart_mode = 1'b1;
      wait_load(10, n);
      chk("rr_seen", load, 1);
      chk("rr_d", d, 8'hC0);
      repeat (3) tick();
      chk("rr_level_pre", level, 3);
      rst = 1'b0;
      #1;
      chk("rr_level", level, 0);
      chk("rr_load", load, 0);
      chk("rr_empty", empty, 1);
      tick();
      chk("rr_load_hold", load, 0);
      uart_mode = 1'b0; man_busy = 1'b0;
      rst = 1'b1;
      tick();
      chk("rr_post_load1", load, 0);
      tick();
      chk("rr_post_load2", load, 0);
      chk("rr_post_level", level, 0);

      // randomized pushes and clears while blocked, against a queue model
      man_busy = 1'b1;
      ovf_m = 1'b0;
      for (int c = 0; c < 60; c++) begin
         wr = ($urandom % 4) != 0;
         din = 8'($urandom);
         clr_ovf = ($urandom % 6) == 0;
         drp = wr && q.size() == 16;
         if (wr && !drp) q.push_back(din);
         ovf_m = drp ? 1'b1 : (clr_ovf ? 1'b0 : ovf_m);
         tick();
         chk("rnd_level", level, q.size());
         chk("rnd_full", full, 32'(q.size() == 16));
         chk("rnd_empty", empty, 32'(q.size() == 0));
         chk("rnd_ovf", overflow, ovf_m);
      end
      wr = 1'b0; clr_ovf = 1'b0;

      // randomized drain with varying transmitter busy time
      uart_mode = 1'b1;
      while (q.size() > 0) begin
         busy_len = $urandom_range(0, 8);
         wait_load(60, n);
         chk("rnd_seen", load, 1);
         chk("rnd_d", d, q.pop_front());
      end
      repeat (20) tick();
      chk("rnd_end_empty", empty, 1);
      chk("rnd_end_level", level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
